// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/handshake bundle between register read, the execute unit and writeback
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            op_5;
    logic            funct7_5;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_op, funct3, op_5, funct7_5, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_op, funct3, op_5, funct7_5, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute stage, single-cycle base ALU plus iterative RV32M multiply/divide
module alu_exec_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input logic            clk,
    input logic            reset_n,
    alu_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND} op_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [SHW-1:0]    r_cnt;
    logic              r_neg;
    logic              r_sel;

    op_t               w_op;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic [2:0]        w_f3;
    logic [SHW-1:0]    w_sh_amt;
    logic [XLEN-1:0]   w_base;
    logic              w_accept;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_div_spec;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN:0]     w_shl;
    logic              w_ge;
    logic [XLEN-1:0]   w_dif;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_div_res;

    assign w_a      = bus.src_a;
    assign w_b      = bus.src_b;
    assign w_f3     = bus.funct3;
    assign w_sh_amt = bus.src_b[SHW-1:0];

    // flush blocks acceptance in its own cycle; DONE frees the slot as soon as the consumer takes the result
    assign bus.in_ready  = !bus.flush && (r_state == S_IDLE || (r_state == S_DONE && bus.out_ready));
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = (r_result == '0);
    assign w_accept      = bus.in_valid && bus.in_ready;

    // ALU-control decode of alu_op/funct3/op_5/funct7_5 into a base operation
    always_comb begin
        w_op = OP_ADD;
        case (bus.alu_op)
            2'b01: w_op = (w_f3[2:1] == 2'b00) ? OP_SUB :
                          (w_f3[2:1] == 2'b10) ? OP_SLT :
                          (w_f3[2:1] == 2'b11) ? OP_SLTU : OP_ADD;
            2'b10: case (w_f3)
                3'b000:  w_op = (bus.op_5 && bus.funct7_5) ? OP_SUB : OP_ADD;
                3'b001:  w_op = OP_SLL;
                3'b010:  w_op = OP_SLT;
                3'b011:  w_op = OP_SLTU;
                3'b100:  w_op = OP_XOR;
                3'b101:  w_op = bus.funct7_5 ? OP_SRA : OP_SRL;
                3'b110:  w_op = OP_OR;
                default: w_op = OP_AND;
            endcase
            default: w_op = OP_ADD;
        endcase
    end

    // single-cycle base datapath
    always_comb begin
        w_base = w_a + w_b;
        case (w_op)
            OP_SUB:  w_base = w_a - w_b;
            OP_SLL:  w_base = w_a << w_sh_amt;
            OP_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            OP_SLTU: w_base = {{(XLEN-1){1'b0}}, w_a < w_b};
            OP_XOR:  w_base = w_a ^ w_b;
            OP_SRL:  w_base = w_a >> w_sh_amt;
            OP_SRA:  w_base = $unsigned($signed(w_a) >>> w_sh_amt);
            OP_OR:   w_base = w_a | w_b;
            OP_AND:  w_base = w_a & w_b;
            default: w_base = w_a + w_b;
        endcase
    end

    // M-extension operand signedness: DIV/REM signed, DIVU/REMU not; MUL/MULH both, MULHSU only A, MULHU none
    assign w_a_sgn    = w_f3[2] ? !w_f3[0] : (w_f3[1:0] != 2'b11);
    assign w_b_sgn    = w_f3[2] ? !w_f3[0] : !w_f3[1];
    assign w_a_neg    = w_a_sgn && w_a[XLEN-1];
    assign w_b_neg    = w_b_sgn && w_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -w_a : w_a;
    assign w_b_mag    = w_b_neg ? -w_b : w_b;
    assign w_div0     = (w_b == '0);
    assign w_ovf      = !w_f3[0] && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
    assign w_div_spec = w_div0 ? (w_f3[1] ? w_a : '1) : (w_f3[1] ? '0 : w_a);

    // one shift-add step; the last step's sum is sign-fixed and written straight into the result
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_mul_res = r_sel ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    // one restoring-divide step; the difference fits XLEN bits whenever it is kept
    assign w_shl     = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = w_shl >= {1'b0, r_dvs};
    assign w_dif     = w_shl[XLEN-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_dif : w_shl[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    assign w_div_res = r_sel ? (r_neg ? -w_rem_nxt : w_rem_nxt) : (r_neg ? -w_quo_nxt : w_quo_nxt);

    // control FSM and iterative datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_sel    <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_result <= w_mul_res;
                        r_state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_result <= w_div_res;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) r_state <= S_IDLE;
                default: ;
            endcase
            if (w_accept) begin
                r_cnt <= '0;
                if (bus.alu_op != 2'b11) begin
                    r_result <= w_base;
                    r_state  <= S_DONE;
                end else if (!w_f3[2]) begin
                    r_acc    <= '0;
                    r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                    r_mplier <= w_b_mag;
                    r_neg    <= w_a_neg ^ w_b_neg;
                    r_sel    <= (w_f3[1:0] != 2'b00);
                    r_state  <= S_MUL;
                end else if (w_div0 || w_ovf) begin
                    r_result <= w_div_spec;
                    r_state  <= S_DONE;
                end else begin
                    r_rem   <= '0;
                    r_quo   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_neg   <= w_f3[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
                    r_sel   <= w_f3[1];
                    r_state <= S_DIV;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit at XLEN=32 and XLEN=16 against an arithmetic model
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        t_sel = 1'b0;
    logic        t_valid = 1'b0;
    logic [1:0]  t_aop = '0;
    logic [2:0]  t_f3 = '0;
    logic        t_op5 = 1'b0;
    logic        t_f75 = 1'b0;
    logic [31:0] t_a = '0;
    logic [31:0] t_b = '0;
    logic        t_flush = 1'b0;
    logic        t_ordy = 1'b1;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_res;
    logic        o_zero;
    int          n_chk = 0;
    int          n_fail = 0;

    alu_exec_unit_if #(.XLEN(32)) b32 ();
    alu_exec_unit_if #(.XLEN(16)) b16 ();

    alu_exec_unit #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32));
    alu_exec_unit #(.XLEN(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));

    always #5 clk = ~clk;

    assign b32.in_valid  = t_valid && !t_sel;
    assign b32.alu_op    = t_aop;
    assign b32.funct3    = t_f3;
    assign b32.op_5      = t_op5;
    assign b32.funct7_5  = t_f75;
    assign b32.src_a     = t_a;
    assign b32.src_b     = t_b;
    assign b32.flush     = t_flush;
    assign b32.out_ready = t_ordy;
    assign b16.in_valid  = t_valid && t_sel;
    assign b16.alu_op    = t_aop;
    assign b16.funct3    = t_f3;
    assign b16.op_5      = t_op5;
    assign b16.funct7_5  = t_f75;
    assign b16.src_a     = t_a[15:0];
    assign b16.src_b     = t_b[15:0];
    assign b16.flush     = t_flush;
    assign b16.out_ready = t_ordy;

    assign o_ready = t_sel ? b16.in_ready  : b32.in_ready;
    assign o_valid = t_sel ? b16.out_valid : b32.out_valid;
    assign o_res   = t_sel ? {16'h0, b16.result} : b32.result;
    assign o_zero  = t_sel ? b16.zero : b32.zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int xl();
        return t_sel ? 16 : 32;
    endfunction

    // RISC-V semantics evaluated on 64-bit integers, then reduced to the operand width
    function automatic logic [31:0] ref_res(input int x, input logic [1:0] aop, input logic [2:0] f3,
                                            input logic op5, input logic f75, input logic [31:0] a, input logic [31:0] b);
        longint mask = (longint'(1) << x) - 1;
        longint half = longint'(1) << (x - 1);
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        longint sa = (ua ^ half) - half;
        longint sb = (ub ^ half) - half;
        int     sh = int'(ub % longint'(x));
        longint r = 0;
        if (aop == 2'd0) r = ua + ub;
        else if (aop == 2'd1) begin
            case (f3[2:1])
                2'd0: r = ua - ub;
                2'd1: r = ua + ub;
                2'd2: r = (sa < sb) ? 1 : 0;
                default: r = (ua < ub) ? 1 : 0;
            endcase
        end else if (aop == 2'd2) begin
            case (f3)
                3'd0: r = (op5 && f75) ? ua - ub : ua + ub;
                3'd1: r = ua << sh;
                3'd2: r = (sa < sb) ? 1 : 0;
                3'd3: r = (ua < ub) ? 1 : 0;
                3'd4: r = ua ^ ub;
                3'd5: r = f75 ? (sa >>> sh) : (ua >> sh);
                3'd6: r = ua | ub;
                default: r = ua & ub;
            endcase
        end else begin
            case (f3)
                3'd0: r = sa * sb;
                3'd1: r = (sa * sb) >>> x;
                3'd2: r = (sa * ub) >>> x;
                3'd3: r = (ua * ub) >> x;
                3'd4: r = (ub == 0) ? -1 : (sa == -half && sb == -1) ? ua : sa / sb;
                3'd5: r = (ub == 0) ? -1 : ua / ub;
                3'd6: r = (ub == 0) ? ua : (sa == -half && sb == -1) ? 0 : sa % sb;
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        return 32'(r & mask);
    endfunction

    function automatic int ref_lat(input int x, input logic [1:0] aop, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
        longint mask = (longint'(1) << x) - 1;
        longint half = longint'(1) << (x - 1);
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        if (aop != 2'd3) return 1;
        if (!f3[2]) return x + 1;
        if (ub == 0) return 1;
        if (!f3[0] && ua == half && ub == mask) return 1;
        return x + 1;
    endfunction

    // drive one operation at a falling edge, hold it until accepted, return one falling edge after the accept
    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic op5, input logic f75,
                         input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        t_aop = aop; t_f3 = f3; t_op5 = op5; t_f75 = f75; t_a = a; t_b = b; t_valid = 1'b1;
        #1;
        while (!o_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("issue_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] aop, input logic [2:0] f3, input logic op5, input logic f75,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int elat);
        int lat = 1;
        issue(aop, f3, op5, f75, a, b);
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_res"}, o_res, exp);
        chk({tag, "_zero"}, {31'd0, o_zero}, {31'd0, exp == 32'd0});
        chk({tag, "_lat"}, lat, elat);
    endtask

    function automatic logic [31:0] pick(input int x);
        logic [31:0] half = 32'd1 << (x - 1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return half;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rnd_sweep(input int nops);
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic        op5;
        logic        f75;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < nops; i++) begin
            aop = 2'($urandom);
            f3  = 3'($urandom);
            op5 = 1'($urandom);
            f75 = 1'($urandom);
            a   = pick(xl());
            b   = pick(xl());
            run($sformatf("rnd%0d_x%0d_op%0d_f%0d_a%h_b%h", i, xl(), aop, f3, a, b), aop, f3, op5, f75, a, b,
                ref_res(xl(), aop, f3, op5, f75, a, b), ref_lat(xl(), aop, f3, a, b));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_valid32", {31'd0, o_valid}, 32'd0);
        chk("rst_zero32", {31'd0, o_zero}, 32'd1);
        chk("rst_res32", o_res, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready32", {31'd0, o_ready}, 32'd1);
        t_sel = 1'b1;
        #1;
        chk("rst_valid16", {31'd0, o_valid}, 32'd0);
        chk("rst_zero16", {31'd0, o_zero}, 32'd1);
        chk("rst_ready16", {31'd0, o_ready}, 32'd1);
        t_sel = 1'b0;
        @(negedge clk);

        run("sub5m7", 2'd2, 3'd0, 1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run("sra31", 2'd2, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1);
        run("sltu", 2'd2, 3'd3, 1'b1, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1);
        run("mulh", 2'd3, 3'd1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mulhsu", 2'd3, 3'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run("mul7x6", 2'd3, 3'd0, 1'b1, 1'b1, 32'd7, 32'd6, 32'd42, 33);
        run("div7by0", 2'd3, 3'd4, 1'b1, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem7by0", 2'd3, 3'd6, 1'b1, 1'b1, 32'd7, 32'd0, 32'd7, 1);
        run("div_ovf", 2'd3, 3'd4, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_m7_2", 2'd3, 3'd6, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu100_7", 2'd3, 3'd5, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 33);

        // back-to-back adds, one result per cycle
        t_aop = 2'd0; t_f3 = 3'd0; t_a = 32'd1; t_b = 32'd100; t_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_valid", i), {31'd0, o_valid}, 32'd1);
            chk($sformatf("b2b%0d_res", i), o_res, 32'd1 + 32'd100 * 32'(i));
            chk($sformatf("b2b%0d_ready", i), {31'd0, o_ready}, 32'd1);
            t_a = 32'd1 + 32'd100 * 32'(i); t_b = 32'd100;
            if (i == 4) t_valid = 1'b0;
        end
        @(negedge clk);

        // backpressure: result held, no acceptance, then accept in the release cycle
        t_ordy = 1'b0;
        issue(2'd0, 3'd0, 1'b0, 1'b0, 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_res", o_res, 32'd30);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            @(negedge clk);
        end
        t_ordy = 1'b1; t_aop = 2'd0; t_a = 32'd1; t_b = 32'd1; t_valid = 1'b1;
        #1;
        chk("bp_accept", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        t_valid = 1'b0;
        chk("bp_new_valid", {31'd0, o_valid}, 32'd1);
        chk("bp_new_res", o_res, 32'd2);
        @(negedge clk);

        // flush at cycle 10 of a multiply
        issue(2'd3, 3'd0, 1'b1, 1'b1, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        t_flush = 1'b1;
        #1;
        chk("flush_ready", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        t_flush = 1'b0;
        #1;
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_idle", {31'd0, o_ready}, 32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) cnt++;
        end
        chk("flush_no_result", cnt, 0);
        run("flush_add", 2'd0, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 1);

        // asynchronous reset in the middle of a divide
        issue(2'd3, 3'd5, 1'b1, 1'b1, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstdiv_valid", {31'd0, o_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) cnt++;
        end
        chk("rstdiv_no_result", cnt, 0);
        chk("rstdiv_ready", {31'd0, o_ready}, 32'd1);
        chk("rstdiv_zero", {31'd0, o_zero}, 32'd1);

        rnd_sweep(150);

        // narrow instance
        t_sel = 1'b1;
        @(negedge clk);
        run("x16_sub5m7", 2'd2, 3'd0, 1'b1, 1'b1, 32'd5, 32'd7, 32'h0000_FFFE, 1);
        run("x16_sra15", 2'd2, 3'd5, 1'b1, 1'b1, 32'h8000, 32'd15, 32'h0000_FFFF, 1);
        run("x16_mul7x6", 2'd3, 3'd0, 1'b1, 1'b1, 32'd7, 32'd6, 32'd42, 17);
        run("x16_div_ovf", 2'd3, 3'd4, 1'b1, 1'b1, 32'h8000, 32'hFFFF, 32'h0000_8000, 1);
        run("x16_divu100_7", 2'd3, 3'd5, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 17);
        rnd_sweep(150);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
